// File: rtl/color_tracker_pkg.sv
// Shared definitions for the colour tracker: RGB565 field positions,
// default frame geometry, tracker FSM encoding and a window-compare helper.
package color_detect_pkg;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        PUBLISH = 2'd3
    } trk_state_e;

    // Inclusive unsigned window test; an inverted window (lo > hi) never matches.
    function automatic logic in_range(input logic [5:0] val, input logic [5:0] lo, input logic [5:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/color_tracker_if.sv
// FIFO read port between the camera output buffer (slave) and the tracker (master).
// rd is a read strobe; data is valid the cycle after a strobe.
interface color_tracker_if;
    logic [15:0] obuf_data;
    logic        obuf_empty;
    logic        obuf_rd;

    modport master (output obuf_rd, input obuf_data, input obuf_empty);
    modport slave  (input obuf_rd, output obuf_data, output obuf_empty);
endinterface

// File: rtl/color_tracker_rgb565_window.sv
// Registered RGB565 window comparator: one-cycle latency from pixel to hit.
module rgb565_window
    import color_detect_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic [15:0] pixel,
    input  logic [4:0]  r_min,
    input  logic [4:0]  r_max,
    input  logic [5:0]  g_min,
    input  logic [5:0]  g_max,
    input  logic [4:0]  b_min,
    input  logic [4:0]  b_max,
    output logic        hit
);

    logic match_s;
    logic hit_r;

    // All three channels must fall inside their inclusive windows.
    always_comb begin
        match_s = in_range({1'b0, pixel[R_MSB:R_LSB]}, {1'b0, r_min}, {1'b0, r_max}) &&
                  in_range(pixel[G_MSB:G_LSB], g_min, g_max) &&
                  in_range({1'b0, pixel[B_MSB:B_LSB]}, {1'b0, b_min}, {1'b0, b_max});
    end

    // Register the compare result; resync drops any in-flight hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_r <= 1'b0;
        end else if (srst) begin
            hit_r <= 1'b0;
        end else begin
            hit_r <= match_s;
        end
    end

    assign hit = hit_r;

endmodule

// File: rtl/color_tracker.sv
// Colour tracker top: drains RGB565 pixels from the camera FIFO, tracks frame
// position, and publishes bounding box and hit count once per frame.
// Optional build macro: TRACK_CENTROID_EN adds hit x/y sum accumulators.
module color_tracker
    import color_detect_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int CW       = 19
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_enable,
    input  logic                 i_resync,
    color_tracker_if.master      obuf,
    input  logic [4:0]           i_r_min,
    input  logic [4:0]           i_r_max,
    input  logic [5:0]           i_g_min,
    input  logic [5:0]           i_g_max,
    input  logic [4:0]           i_b_min,
    input  logic [4:0]           i_b_max,
    output logic                 o_valid,
    output logic                 o_found,
    output logic [XW-1:0]        o_xmin,
    output logic [XW-1:0]        o_xmax,
    output logic [YW-1:0]        o_ymin,
    output logic [YW-1:0]        o_ymax,
    output logic [CW-1:0]        o_count,
    output logic [XW+CW-1:0]     o_sum_x,
    output logic [YW+CW-1:0]     o_sum_y,
    output logic                 o_busy
);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
    localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
    localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_SAT  = {CW{1'b1}};

    trk_state_e    state_r, state_nxt_s;
    logic          drain_cnt_r;
    logic          frame_start_s, publish_s, rd_s, last_rd_s, hit_s;

    logic [XW-1:0] x_r, x_nxt_s, p1_x_r, p2_x_r;
    logic [YW-1:0] y_r, y_nxt_s, p1_y_r, p2_y_r;
    logic          p1_vld_r, p2_vld_r;

    logic [4:0]    sh_r_min_r, sh_r_max_r, sh_b_min_r, sh_b_max_r;
    logic [5:0]    sh_g_min_r, sh_g_max_r;

    logic [XW-1:0] acc_xmin_r, acc_xmax_r, acc_xmin_nxt_s, acc_xmax_nxt_s;
    logic [YW-1:0] acc_ymin_r, acc_ymax_r, acc_ymin_nxt_s, acc_ymax_nxt_s;
    logic [CW-1:0] acc_count_r, acc_count_nxt_s;
    logic          acc_hit_s;

    logic          valid_r, found_r, busy_r;
    logic [XW-1:0] xmin_r, xmax_r;
    logic [YW-1:0] ymin_r, ymax_r;
    logic [CW-1:0] count_r;

    // Reads only while running; resync suppresses the strobe so no pixel is popped and lost.
    assign rd_s          = (state_r == RUN) && !obuf.obuf_empty && !i_resync;
    assign last_rd_s     = rd_s && (x_r == X_LAST) && (y_r == Y_LAST);
    assign publish_s     = (state_r == DRAIN) && drain_cnt_r;
    assign obuf.obuf_rd  = rd_s;

    // Next-state logic; a new frame only starts at position (0,0).
    always_comb begin
        state_nxt_s   = state_r;
        frame_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_enable && (x_r == X_ZERO) && (y_r == Y_ZERO)) begin
                    state_nxt_s   = RUN;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_rd_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_cnt_r) begin
                    state_nxt_s = PUBLISH;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            PUBLISH: begin
                if (i_enable) begin
                    state_nxt_s   = RUN;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus the two-cycle drain timer.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r     <= IDLE;
            drain_cnt_r <= 1'b0;
        end else if (i_resync) begin
            state_r     <= IDLE;
            drain_cnt_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
        end
    end

    // Raster position after the current accepted pixel.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if (x_r == X_LAST) begin
            x_nxt_s = X_ZERO;
            y_nxt_s = (y_r == Y_LAST) ? Y_ZERO : (y_r + {{(YW-1){1'b0}}, 1'b1});
        end else begin
            x_nxt_s = x_r + {{(XW-1){1'b0}}, 1'b1};
        end
    end

    // Position counter and the coordinate/valid pipeline that tracks each read to its hit.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_r      <= X_ZERO;
            y_r      <= Y_ZERO;
            p1_vld_r <= 1'b0;
            p2_vld_r <= 1'b0;
            p1_x_r   <= X_ZERO;
            p1_y_r   <= Y_ZERO;
            p2_x_r   <= X_ZERO;
            p2_y_r   <= Y_ZERO;
        end else if (i_resync) begin
            x_r      <= X_ZERO;
            y_r      <= Y_ZERO;
            p1_vld_r <= 1'b0;
            p2_vld_r <= 1'b0;
            p1_x_r   <= X_ZERO;
            p1_y_r   <= Y_ZERO;
            p2_x_r   <= X_ZERO;
            p2_y_r   <= Y_ZERO;
        end else begin
            x_r      <= rd_s ? x_nxt_s : x_r;
            y_r      <= rd_s ? y_nxt_s : y_r;
            p1_vld_r <= rd_s;
            p1_x_r   <= x_r;
            p1_y_r   <= y_r;
            p2_vld_r <= p1_vld_r;
            p2_x_r   <= p1_x_r;
            p2_y_r   <= p1_y_r;
        end
    end

    // Threshold shadows, frozen for the whole frame.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sh_r_min_r <= 5'd0;
            sh_r_max_r <= 5'd0;
            sh_g_min_r <= 6'd0;
            sh_g_max_r <= 6'd0;
            sh_b_min_r <= 5'd0;
            sh_b_max_r <= 5'd0;
        end else if (!i_resync && frame_start_s) begin
            sh_r_min_r <= i_r_min;
            sh_r_max_r <= i_r_max;
            sh_g_min_r <= i_g_min;
            sh_g_max_r <= i_g_max;
            sh_b_min_r <= i_b_min;
            sh_b_max_r <= i_b_max;
        end else begin
            sh_r_min_r <= sh_r_min_r;
            sh_r_max_r <= sh_r_max_r;
            sh_g_min_r <= sh_g_min_r;
            sh_g_max_r <= sh_g_max_r;
            sh_b_min_r <= sh_b_min_r;
            sh_b_max_r <= sh_b_max_r;
        end
    end

    rgb565_window u_window (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .srst  (i_resync),
        .pixel (obuf.obuf_data),
        .r_min (sh_r_min_r),
        .r_max (sh_r_max_r),
        .g_min (sh_g_min_r),
        .g_max (sh_g_max_r),
        .b_min (sh_b_min_r),
        .b_max (sh_b_max_r),
        .hit   (hit_s)
    );

    assign acc_hit_s = p2_vld_r && hit_s;

    // Bounding-box and count update for the pixel leaving the pipeline.
    always_comb begin
        acc_xmin_nxt_s  = acc_xmin_r;
        acc_xmax_nxt_s  = acc_xmax_r;
        acc_ymin_nxt_s  = acc_ymin_r;
        acc_ymax_nxt_s  = acc_ymax_r;
        acc_count_nxt_s = acc_count_r;
        if (acc_hit_s) begin
            acc_xmin_nxt_s  = (p2_x_r < acc_xmin_r) ? p2_x_r : acc_xmin_r;
            acc_xmax_nxt_s  = (p2_x_r > acc_xmax_r) ? p2_x_r : acc_xmax_r;
            acc_ymin_nxt_s  = (p2_y_r < acc_ymin_r) ? p2_y_r : acc_ymin_r;
            acc_ymax_nxt_s  = (p2_y_r > acc_ymax_r) ? p2_y_r : acc_ymax_r;
            acc_count_nxt_s = (acc_count_r == C_SAT) ? acc_count_r : (acc_count_r + C_ONE);
        end else begin
            acc_count_nxt_s = acc_count_r;
        end
    end

    // Frame accumulators: seeded at frame start, cleared by resync.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_xmin_r  <= X_ZERO;
            acc_xmax_r  <= X_ZERO;
            acc_ymin_r  <= Y_ZERO;
            acc_ymax_r  <= Y_ZERO;
            acc_count_r <= C_ZERO;
        end else if (i_resync) begin
            acc_xmin_r  <= X_ZERO;
            acc_xmax_r  <= X_ZERO;
            acc_ymin_r  <= Y_ZERO;
            acc_ymax_r  <= Y_ZERO;
            acc_count_r <= C_ZERO;
        end else if (frame_start_s) begin
            acc_xmin_r  <= X_LAST;
            acc_xmax_r  <= X_ZERO;
            acc_ymin_r  <= Y_LAST;
            acc_ymax_r  <= Y_ZERO;
            acc_count_r <= C_ZERO;
        end else begin
            acc_xmin_r  <= acc_xmin_nxt_s;
            acc_xmax_r  <= acc_xmax_nxt_s;
            acc_ymin_r  <= acc_ymin_nxt_s;
            acc_ymax_r  <= acc_ymax_nxt_s;
            acc_count_r <= acc_count_nxt_s;
        end
    end

    // Result registers: loaded from the post-update accumulators as the final pixel retires.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_r <= 1'b0;
            found_r <= 1'b0;
            xmin_r  <= X_ZERO;
            xmax_r  <= X_ZERO;
            ymin_r  <= Y_ZERO;
            ymax_r  <= Y_ZERO;
            count_r <= C_ZERO;
            busy_r  <= 1'b0;
        end else if (i_resync) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            valid_r <= publish_s;
            busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == PUBLISH);
            if (publish_s) begin
                found_r <= (acc_count_nxt_s != C_ZERO);
                xmin_r  <= (acc_count_nxt_s != C_ZERO) ? acc_xmin_nxt_s : X_ZERO;
                xmax_r  <= (acc_count_nxt_s != C_ZERO) ? acc_xmax_nxt_s : X_ZERO;
                ymin_r  <= (acc_count_nxt_s != C_ZERO) ? acc_ymin_nxt_s : Y_ZERO;
                ymax_r  <= (acc_count_nxt_s != C_ZERO) ? acc_ymax_nxt_s : Y_ZERO;
                count_r <= acc_count_nxt_s;
            end else begin
                found_r <= found_r;
                count_r <= count_r;
            end
        end
    end

`ifdef TRACK_CENTROID_EN
    logic [XW+CW-1:0] sum_x_r, sum_x_nxt_s, out_sum_x_r;
    logic [YW+CW-1:0] sum_y_r, sum_y_nxt_s, out_sum_y_r;

    // Coordinate sums for hits, for centroid computation downstream.
    always_comb begin
        sum_x_nxt_s = sum_x_r;
        sum_y_nxt_s = sum_y_r;
        if (acc_hit_s) begin
            sum_x_nxt_s = sum_x_r + {{CW{1'b0}}, p2_x_r};
            sum_y_nxt_s = sum_y_r + {{CW{1'b0}}, p2_y_r};
        end else begin
            sum_x_nxt_s = sum_x_r;
        end
    end

    // Sum accumulators and their published copies.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sum_x_r     <= {(XW+CW){1'b0}};
            sum_y_r     <= {(YW+CW){1'b0}};
            out_sum_x_r <= {(XW+CW){1'b0}};
            out_sum_y_r <= {(YW+CW){1'b0}};
        end else if (i_resync || frame_start_s) begin
            sum_x_r     <= {(XW+CW){1'b0}};
            sum_y_r     <= {(YW+CW){1'b0}};
        end else begin
            sum_x_r     <= sum_x_nxt_s;
            sum_y_r     <= sum_y_nxt_s;
            out_sum_x_r <= publish_s ? sum_x_nxt_s : out_sum_x_r;
            out_sum_y_r <= publish_s ? sum_y_nxt_s : out_sum_y_r;
        end
    end

    assign o_sum_x = out_sum_x_r;
    assign o_sum_y = out_sum_y_r;
`else
    assign o_sum_x = {(XW+CW){1'b0}};
    assign o_sum_y = {(YW+CW){1'b0}};
`endif

    assign o_valid = valid_r;
    assign o_found = found_r;
    assign o_xmin  = xmin_r;
    assign o_xmax  = xmax_r;
    assign o_ymin  = ymin_r;
    assign o_ymax  = ymax_r;
    assign o_count = count_r;
    assign o_busy  = busy_r;

endmodule
